// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mips_ctrl_pkg
// Purpose : Shared encodings for the multicycle MIPS controller: FSM states,
//           opcodes, ALU operation codes, PC/register/writeback selects and
//           exception causes. The ALU decoder reuses the aluop encodings.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package mips_ctrl_pkg;

    typedef enum logic [4:0] {
        S_FETCH   = 5'd0,
        S_DECODE  = 5'd1,
        S_MEMADR  = 5'd2,
        S_MEMRD   = 5'd3,
        S_MEMWB   = 5'd4,
        S_MEMWR   = 5'd5,
        S_RTYPEEX = 5'd6,
        S_RTYPEWB = 5'd7,
        S_BEQEX   = 5'd8,
        S_BNEEX   = 5'd9,
        S_IMMEX   = 5'd10,
        S_IMMWB   = 5'd11,
        S_JEX     = 5'd12,
        S_JALEX   = 5'd13,
        S_EXCEPT  = 5'd14
    } state_t;

    // Opcodes (IR[31:26])
    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_J     = 6'b000010;
    localparam logic [5:0] c_OP_JAL   = 6'b000011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_BNE   = 6'b000101;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_SLTI  = 6'b001010;
    localparam logic [5:0] c_OP_ANDI  = 6'b001100;
    localparam logic [5:0] c_OP_ORI   = 6'b001101;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;

    // ALU operation requested from the ALU decoder
    localparam logic [2:0] c_ALU_ADD   = 3'b000;
    localparam logic [2:0] c_ALU_SUB   = 3'b001;
    localparam logic [2:0] c_ALU_FUNCT = 3'b010;
    localparam logic [2:0] c_ALU_OR    = 3'b011;
    localparam logic [2:0] c_ALU_AND   = 3'b100;
    localparam logic [2:0] c_ALU_SLT   = 3'b101;

    // Next-PC source
    localparam logic [1:0] c_PC_ALU    = 2'b00;
    localparam logic [1:0] c_PC_ALUOUT = 2'b01;
    localparam logic [1:0] c_PC_JUMP   = 2'b10;
    localparam logic [1:0] c_PC_EXC    = 2'b11;

    // Destination register select
    localparam logic [1:0] c_DST_RT  = 2'b00;
    localparam logic [1:0] c_DST_RD  = 2'b01;
    localparam logic [1:0] c_DST_R31 = 2'b10;

    // Register writeback source
    localparam logic [1:0] c_WB_ALUOUT = 2'b00;
    localparam logic [1:0] c_WB_MDR    = 2'b01;
    localparam logic [1:0] c_WB_PC     = 2'b10;

    // ALU B operand select
    localparam logic [1:0] c_SRCB_B     = 2'b00;
    localparam logic [1:0] c_SRCB_FOUR  = 2'b01;
    localparam logic [1:0] c_SRCB_IMM   = 2'b10;
    localparam logic [1:0] c_SRCB_IMMSH = 2'b11;

    // Exception cause
    localparam logic [1:0] c_CAUSE_NONE    = 2'b00;
    localparam logic [1:0] c_CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] c_CAUSE_TIMEOUT = 2'b10;

    // ALU operation for the immediate-ALU instructions
    function automatic logic [2:0] imm_aluop(input logic [5:0] op);
        case (op)
            c_OP_SLTI: imm_aluop = c_ALU_SLT;
            c_OP_ANDI: imm_aluop = c_ALU_AND;
            c_OP_ORI:  imm_aluop = c_ALU_OR;
            default:   imm_aluop = c_ALU_ADD;
        endcase
    endfunction

    // Logical immediates are zero-extended, arithmetic ones sign-extended
    function automatic logic imm_zext(input logic [5:0] op);
        imm_zext = (op == c_OP_ANDI) || (op == c_OP_ORI);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_wait_timer.sv
`default_nettype none
// ============================================================================
// Module  : mem_wait_timer
// Purpose : Counts stall cycles spent waiting for memory and flags the cycle
//           in which one more stall would exceed TIMEOUT cycles.
// Ports   : clk     - rising-edge clock
//           reset   - asynchronous active-low reset
//           clear   - restart count at 0 (FSM is changing state)
//           enable  - FSM is in a memory-wait state
//           ready   - memory completes the access this cycle
//           expire  - waiting, not ready and count already at TIMEOUT-1
// Rev     : 1.0  initial release
// ============================================================================
module mem_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    input  logic ready,
    output logic expire
);

    localparam int            CW     = $clog2(TIMEOUT);
    localparam logic [CW-1:0] c_LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_count;
    logic          w_stall;

    assign w_stall = enable && !ready;
    // A ready in the last cycle masks the expiry, so completion wins over trap
    assign expire  = w_stall && (r_count == c_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (w_stall) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/maindec_mc.sv
`default_nettype none
// ============================================================================
// Module  : maindec_mc
// Purpose : Multicycle MIPS main controller. Moore FSM decoding op into
//           datapath strobes and mux selects, with a memory ready handshake,
//           wait timeout and illegal-opcode / bus-timeout exceptions.
// Ports   : clk, reset (async active-low), op[5:0], mem_ready
//           strobes  : pcWrite, MemWrite, IRWrite, RegWrite, mem_req
//           selects  : alusrca, branch, bne, iord, immzext, MemtoReg[1:0],
//                      regDST[1:0], alusrcb[1:0], pcsrc[1:0], aluop[2:0]
//           status   : exc (pulse), exc_cause[1:0] (held), instr_done
// Rev     : 1.0  initial release
// ============================================================================
module maindec_mc
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_WAIT_EN = 1,
    parameter int TIMEOUT     = 16,
    parameter int EXC_EN      = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output logic       pcWrite,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       alusrca,
    output logic       branch,
    output logic       bne,
    output logic       iord,
    output logic       immzext,
    output logic [1:0] MemtoReg,
    output logic [1:0] regDST,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] aluop,
    output logic       mem_req,
    output logic       exc,
    output logic [1:0] exc_cause,
    output logic       instr_done
);

    state_t     r_state;
    state_t     w_next;
    logic [1:0] r_exc_cause;
    logic [1:0] w_cause;
    logic       w_rdy;
    logic       w_waiting;
    logic       w_expire;

    // Without the handshake every memory state completes in one cycle
    generate
        if (MEM_WAIT_EN != 0) begin : g_wait
            assign w_rdy     = mem_ready;
            assign w_waiting = (r_state == S_FETCH) || (r_state == S_MEMRD) ||
                               (r_state == S_MEMWR);
        end else begin : g_nowait
            assign w_rdy     = 1'b1;
            assign w_waiting = 1'b0;
        end
    endgenerate

    // Any state change restarts the count, which covers entry to each wait state
    mem_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (w_next != r_state),
        .enable (w_waiting),
        .ready  (w_rdy),
        .expire (w_expire)
    );

    // Next-state and exception cause
    always_comb begin
        w_next  = S_FETCH;
        w_cause = c_CAUSE_NONE;
        case (r_state)
            S_FETCH, S_MEMRD, S_MEMWR: begin
                if (w_rdy) begin
                    w_next = (r_state == S_FETCH) ? S_DECODE :
                             (r_state == S_MEMRD) ? S_MEMWB  : S_FETCH;
                end else if (w_expire) begin
                    w_next  = S_EXCEPT;
                    w_cause = c_CAUSE_TIMEOUT;
                end else begin
                    w_next = r_state;
                end
            end
            S_DECODE: begin
                case (op)
                    c_OP_LW, c_OP_SW:   w_next = S_MEMADR;
                    c_OP_RTYPE:         w_next = S_RTYPEEX;
                    c_OP_BEQ:           w_next = S_BEQEX;
                    c_OP_BNE:           w_next = S_BNEEX;
                    c_OP_ADDI, c_OP_SLTI,
                    c_OP_ANDI, c_OP_ORI: w_next = S_IMMEX;
                    c_OP_J:             w_next = S_JEX;
                    c_OP_JAL:           w_next = S_JALEX;
                    default: begin
                        if (EXC_EN != 0) begin
                            w_next  = S_EXCEPT;
                            w_cause = c_CAUSE_ILLEGAL;
                        end else begin
                            w_next = S_FETCH;
                        end
                    end
                endcase
            end
            S_MEMADR:  w_next = (op == c_OP_SW) ? S_MEMWR : S_MEMRD;
            S_RTYPEEX: w_next = S_RTYPEWB;
            S_IMMEX:   w_next = S_IMMWB;
            default:   w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_FETCH;
            r_exc_cause <= c_CAUSE_NONE;
        end else begin
            r_state <= w_next;
            if (w_next == S_EXCEPT) begin
                r_exc_cause <= w_cause;
            end
        end
    end

    assign exc_cause = r_exc_cause;

    // Output decode; strobes in memory states are qualified by w_rdy
    always_comb begin
        pcWrite    = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        alusrca    = 1'b0;
        branch     = 1'b0;
        bne        = 1'b0;
        iord       = 1'b0;
        immzext    = 1'b0;
        MemtoReg   = c_WB_ALUOUT;
        regDST     = c_DST_RT;
        alusrcb    = c_SRCB_B;
        pcsrc      = c_PC_ALU;
        aluop      = c_ALU_ADD;
        mem_req    = 1'b0;
        exc        = 1'b0;
        instr_done = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_req = 1'b1;
                alusrcb = c_SRCB_FOUR;
                IRWrite = w_rdy;
                pcWrite = w_rdy;
            end
            S_DECODE: alusrcb = c_SRCB_IMMSH;
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = c_SRCB_IMM;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            S_MEMWB: begin
                RegWrite   = 1'b1;
                MemtoReg   = c_WB_MDR;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                mem_req    = 1'b1;
                iord       = 1'b1;
                MemWrite   = w_rdy;
                instr_done = w_rdy;
            end
            S_RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = c_ALU_FUNCT;
            end
            S_RTYPEWB: begin
                RegWrite   = 1'b1;
                regDST     = c_DST_RD;
                instr_done = 1'b1;
            end
            S_BEQEX, S_BNEEX: begin
                alusrca    = 1'b1;
                branch     = 1'b1;
                bne        = (r_state == S_BNEEX);
                pcsrc      = c_PC_ALUOUT;
                aluop      = c_ALU_SUB;
                instr_done = 1'b1;
            end
            S_IMMEX: begin
                alusrca = 1'b1;
                alusrcb = c_SRCB_IMM;
                aluop   = imm_aluop(op);
                immzext = imm_zext(op);
            end
            S_IMMWB: begin
                RegWrite   = 1'b1;
                aluop      = imm_aluop(op);
                immzext    = imm_zext(op);
                instr_done = 1'b1;
            end
            S_JEX: begin
                pcWrite    = 1'b1;
                pcsrc      = c_PC_JUMP;
                instr_done = 1'b1;
            end
            S_JALEX: begin
                // PC already holds PC+4 from FETCH, so it is the link value
                pcWrite    = 1'b1;
                pcsrc      = c_PC_JUMP;
                RegWrite   = 1'b1;
                regDST     = c_DST_R31;
                MemtoReg   = c_WB_PC;
                instr_done = 1'b1;
            end
            S_EXCEPT: begin
                pcWrite = 1'b1;
                pcsrc   = c_PC_EXC;
                exc     = 1'b1;
            end
            default: ;
        endcase
        // Nothing may strobe while reset is held, even though state reads FETCH
        if (!reset) begin
            pcWrite    = 1'b0;
            MemWrite   = 1'b0;
            IRWrite    = 1'b0;
            RegWrite   = 1'b0;
            alusrca    = 1'b0;
            branch     = 1'b0;
            bne        = 1'b0;
            iord       = 1'b0;
            immzext    = 1'b0;
            MemtoReg   = c_WB_ALUOUT;
            regDST     = c_DST_RT;
            alusrcb    = c_SRCB_B;
            pcsrc      = c_PC_ALU;
            aluop      = c_ALU_ADD;
            mem_req    = 1'b0;
            exc        = 1'b0;
            instr_done = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: doc/maindec_mc.md
Name: maindec_mc

Overview:
- Next-generation multicycle MIPS main controller. A Moore FSM decodes the 6-bit opcode from IR and drives datapath strobes and mux selects.
- Extends the six-instruction set with BNE, ORI, ANDI, SLTI and JAL.
- Adds a variable-latency memory handshake with a wait timeout.
- Illegal opcodes and memory timeouts trap to an exception vector.
- Sits in the multicycle core's controller, beside the ALU decoder.

Parameters:
- MEM_WAIT_EN, 1: 1 = memory states stall until mem_ready; 0 = memory states take one cycle and mem_ready is ignored.
- TIMEOUT, 16: maximum wait cycles in a memory state before a bus-error trap. Legal range 2..255.
- EXC_EN, 1: 1 = illegal opcode traps to EXCEPT; 0 = illegal opcode returns to FETCH with no side effect.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- op  in  6  opcode, IR[31:26], stable from DECODE onward.
- mem_ready  in  1  memory completes the current access this cycle.
- pcWrite, MemWrite, IRWrite, RegWrite  out  1 each  write strobes.
- alusrca, branch, bne, iord, immzext  out  1 each  selects/qualifiers; immzext = zero-extend the immediate.
- MemtoReg  out  2  00 ALUOut, 01 MDR, 10 PC.
- regDST  out  2  00 rt, 01 rd, 10 r31.
- alusrcb  out  2  00 B, 01 const 4, 10 imm, 11 imm<<2.
- pcsrc  out  2  00 ALU, 01 ALUOut, 10 jump target, 11 exception vector.
- aluop  out  3  000 add, 001 sub, 010 funct, 011 or, 100 and, 101 slt.
- mem_req  out  1  memory access request.
- exc  out  1  one-cycle pulse on entry to EXCEPT.
- exc_cause  out  2  00 none, 01 illegal opcode, 10 bus timeout; held until the next exception.
- instr_done  out  1  pulse in the final state of each completed instruction.

Behaviour:
- Reset (reset=0, async): state <= FETCH, wait counter <= 0, exc_cause <= 00. While reset=0, all strobes, mem_req, exc and instr_done are forced to 0.
- Outputs are a combinational decode of state, except where gated by mem_ready as described below.
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQEX, BNEEX, IMMEX, IMMWB, JEX, JALEX, EXCEPT.
- FETCH: mem_req=1, iord=0, alusrcb=01, aluop=add. IRWrite=pcWrite=mem_ready (both forced 1 when MEM_WAIT_EN=0). Advance to DECODE on mem_ready.
- DECODE: alusrcb=11, aluop=add. Next state by op:
  - LW/SW -> MEMADR
  - 000000 -> RTYPEEX
  - BEQ -> BEQEX
  - BNE 000101 -> BNEEX
  - ADDI, SLTI 001010, ANDI 001100, ORI 001101 -> IMMEX
  - J -> JEX
  - JAL 000011 -> JALEX
  - any other op -> EXCEPT (EXC_EN=1) or FETCH (EXC_EN=0)
- MEMADR: alusrca=1, alusrcb=10, aluop=add. LW -> MEMRD; SW -> MEMWR.
- MEMRD: mem_req=1, iord=1; wait for mem_ready, then -> MEMWB.
- MEMWR: mem_req=1, iord=1, MemWrite=mem_ready; -> FETCH on mem_ready.
- MEMWB: RegWrite=1, MemtoReg=01, regDST=00.
- RTYPEEX: alusrca=1, alusrcb=00, aluop=010. RTYPEWB: RegWrite=1, regDST=01, MemtoReg=00.
- BEQEX: alusrca=1, branch=1, pcsrc=01, aluop=sub. BNEEX: same controls plus bne=1, so the PC is written on the not-zero condition.
- IMMEX: alusrca=1, alusrcb=10. aluop: add (ADDI), slt (SLTI), and (ANDI), or (ORI). immzext=1 for ANDI/ORI only.
- IMMWB: RegWrite=1, regDST=00, MemtoReg=00. IMMWB still sees op and keeps immzext/aluop consistent with IMMEX.
- JEX: pcWrite=1, pcsrc=10.
- JALEX: pcWrite=1, pcsrc=10, RegWrite=1, regDST=10, MemtoReg=10. Writes PC+4, already incremented in FETCH, to r31.
- instr_done=1 in MEMWB, MEMWR (with mem_ready), RTYPEWB, BEQEX, BNEEX, IMMWB, JEX, JALEX. All of these return to FETCH.
- Wait counter (MEM_WAIT_EN=1):
  - Cleared on entry to FETCH, MEMRD or MEMWR; increments each cycle the FSM is in one of them with mem_ready=0.
  - If mem_ready=0 while the counter equals TIMEOUT-1 -> EXCEPT with cause 10.
  - mem_ready=1 in that same cycle wins: normal advance, no trap.
- EXCEPT: pcWrite=1, pcsrc=11, exc=1, exc_cause latched; then -> FETCH. No RegWrite or MemWrite is ever asserted in EXCEPT.
- Reset asserted mid-instruction or mid-wait aborts immediately. No partial strobes occur after reset is asserted.
- Unused state encodings -> FETCH, with outputs 0.

Decomposition:
- Package mips_ctrl_pkg holds state encodings (5-bit), opcode constants, aluop, pcsrc, regDST and MemtoReg encodings. The ALU decoder reuses the aluop encodings.
- One sub-module, mem_wait_timer: counter of width $clog2(TIMEOUT), with clear, enable, ready and expire outputs.

Test Plan:
- LW with mem_ready tied 1: 5 cycles, FETCH->DECODE->MEMADR->MEMRD->MEMWB; RegWrite=1, MemtoReg=01 in cycle 5; instr_done pulses once.
- SW with mem_ready delayed 3 cycles in MEMWR: MemWrite low for 3 cycles, high exactly one cycle, mem_req high all 4 cycles, then FETCH.
- BNE (000101): BNEEX shows branch=1, bne=1, aluop=001, pcsrc=01; ORI (001101): immzext=1, aluop=011 in IMMEX and IMMWB.
- JAL: JALEX drives pcWrite=1, RegWrite=1, regDST=10, MemtoReg=10, pcsrc=10 in one cycle.
- op=111111 with EXC_EN=1: EXCEPT follows DECODE, exc=1 for one cycle, exc_cause=01, pcsrc=11; no RegWrite or MemWrite.
- FETCH with mem_ready held 0 (TIMEOUT=16): EXCEPT entered after 16 FETCH cycles, exc_cause=10. A repeat run with mem_ready=1 in the 16th cycle -> DECODE, no trap. Asserting reset in the 8th wait cycle -> FETCH, counter 0, exc_cause 00.
